// File: rtl/urng_sched_if.sv
// rtl/urng_sched_if.sv - URNG scheduler bus: enable, requests, URNG word in, grant/data/status out
interface urng_sched_if #(
    parameter int N  = 4,
    parameter int DW = 32,
    parameter int CW = 16
);
    logic          EN;
    logic [N-1:0]  REQ;
    logic [DW-1:0] TAU_IN;
    logic          ST_OUT;
    logic [N-1:0]  GNT;
    logic          VLD;
    logic [DW-1:0] DATA;
    logic          BUSY;
    logic [CW-1:0] DROPS;

    modport master (
        input  EN, REQ, TAU_IN,
        output ST_OUT, GNT, VLD, DATA, BUSY, DROPS
    );

    modport slave (
        output EN, REQ, TAU_IN,
        input  ST_OUT, GNT, VLD, DATA, BUSY, DROPS
    );
endinterface

// File: rtl/urng_sched.sv
// rtl/urng_sched.sv - round-robin scheduler sharing Tausworthe URNG words among N requesters
module urng_sched #(
    parameter int N  = 4,
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic         CK,
    input  logic         RB,
    urng_sched_if.master bus
);
    localparam int LW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, SEED, RUN} state_t;

    state_t        state, state_n;
    logic [1:0]    ph, ph_n;
    logic          taken, taken_n;
    logic [LW-1:0] last, last_n, pick;
    logic [N-1:0]  hi_req;
    logic          grant;
    logic          st_q, st_n, vld_q, vld_n, busy_q, busy_n;
    logic [N-1:0]  gnt_q, gnt_n;
    logic [DW-1:0] data_q, data_n;
    logic [CW-1:0] drops_q, drops_n;

    // first request above LAST wins; otherwise wrap to the lowest request
    always_comb begin
        hi_req = '0;
        for (int i = 0; i < N; i++) begin
            hi_req[i] = bus.REQ[i] && (i > int'(last));
        end
        pick = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (bus.REQ[i]) pick = i[LW-1:0];
        end
        if (hi_req != '0) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (hi_req[i]) pick = i[LW-1:0];
            end
        end
    end

    always_comb begin
        state_n = state;
        ph_n    = ph;
        taken_n = taken;
        last_n  = last;
        gnt_n   = '0;
        vld_n   = 1'b0;
        data_n  = data_q;
        drops_n = drops_q;
        grant   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.EN) state_n = SEED;
            end
            SEED: begin
                state_n = RUN;
                ph_n    = 2'd0;
                taken_n = 1'b0;
            end
            RUN: begin
                ph_n = ph + 2'd1;
                if (!bus.EN) begin
                    state_n = IDLE;
                end else begin
                    grant = (bus.REQ != '0) && !taken;
                    if (grant) begin
                        gnt_n[pick] = 1'b1;
                        vld_n       = 1'b1;
                        data_n      = bus.TAU_IN;
                        last_n      = pick;
                        taken_n     = 1'b1;
                    end
                    // URNG steps on this edge, so the next sample starts untaken
                    if (ph == 2'd3) begin
                        taken_n = 1'b0;
                        if (!taken && !grant && drops_q != '1) drops_n = drops_q + CW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        st_n   = (state_n == SEED);
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge CK or posedge RB) begin
        if (RB) begin
            state   <= IDLE;
            ph      <= 2'd0;
            taken   <= 1'b0;
            last    <= LW'(N - 1);
            st_q    <= 1'b0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            gnt_q   <= '0;
            data_q  <= '0;
            drops_q <= '0;
        end else begin
            state   <= state_n;
            ph      <= ph_n;
            taken   <= taken_n;
            last    <= last_n;
            st_q    <= st_n;
            vld_q   <= vld_n;
            busy_q  <= busy_n;
            gnt_q   <= gnt_n;
            data_q  <= data_n;
            drops_q <= drops_n;
        end
    end

    assign bus.ST_OUT = st_q;
    assign bus.GNT    = gnt_q;
    assign bus.VLD    = vld_q;
    assign bus.DATA   = data_q;
    assign bus.BUSY   = busy_q;
    assign bus.DROPS  = drops_q;
endmodule

// File: tb/tb_urng_sched.sv
// tb/tb_urng_sched.sv - directed vector bench for urng_sched with a Tausworthe URNG model
module tb_urng_sched;
    logic CK = 1'b0;
    logic RB = 1'b1;
    always #5 CK = ~CK;

    urng_sched_if #(.N(4), .DW(32), .CW(16)) bus ();
    urng_sched_if #(.N(4), .DW(32), .CW(2))  bus2 ();

    urng_sched #(.N(4), .DW(32), .CW(16)) dut  (.CK(CK), .RB(RB), .bus(bus));
    urng_sched #(.N(4), .DW(32), .CW(2))  dut2 (.CK(CK), .RB(RB), .bus(bus2));

    localparam logic [95:0] SEEDS = {32'd20, 32'd16, 32'd7};

    function automatic logic [95:0] taus_step(input logic [95:0] s);
        logic [31:0] s1, s2, s3, b;
        s1 = s[95:64];
        s2 = s[63:32];
        s3 = s[31:0];
        b  = ((s1 << 13) ^ s1) >> 19;
        s1 = ((s1 & 32'hFFFFFFFE) << 12) ^ b;
        b  = ((s2 << 2) ^ s2) >> 25;
        s2 = ((s2 & 32'hFFFFFFF8) << 4) ^ b;
        b  = ((s3 << 3) ^ s3) >> 11;
        s3 = ((s3 & 32'hFFFFFFF0) << 17) ^ b;
        return {s1, s2, s3};
    endfunction

    // URNG: ST loads the seeds and clears its counter; it steps every fourth cycle
    logic [95:0] urng;
    logic [1:0]  ucnt;
    always @(posedge CK or posedge RB) begin
        if (RB) begin
            urng <= SEEDS;
            ucnt <= 2'd0;
        end else if (bus.ST_OUT) begin
            urng <= SEEDS;
            ucnt <= 2'd0;
        end else begin
            ucnt <= ucnt + 2'd1;
            if (ucnt == 2'd3) urng <= taus_step(urng);
        end
    end

    assign bus.TAU_IN  = urng[95:64] ^ urng[63:32] ^ urng[31:0];
    assign bus2.TAU_IN = bus.TAU_IN;
    assign bus2.EN     = bus.EN;
    assign bus2.REQ    = bus.REQ;

    typedef struct {
        logic        en;
        logic [3:0]  req;
        logic        st;
        logic        busy;
        logic        vld;
        logic [3:0]  gnt;
        logic [31:0] data;
        logic [15:0] drops;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] g[16];
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic en, input logic [3:0] req, input logic st, input logic busy,
                       input logic vld, input logic [3:0] gnt, input logic [31:0] data,
                       input logic [15:0] drops);
        vec_t v;
        v.en = en; v.req = req; v.st = st; v.busy = busy;
        v.vld = vld; v.gnt = gnt; v.data = data; v.drops = drops;
        tbl.push_back(v);
    endtask

    // four edges of one sample: grant on the edge ending ph0, then quiet
    task automatic add_sample(input logic [3:0] req, input logic [3:0] gnt,
                              input logic [31:0] data, input logic [15:0] drops);
        add(1'b1, req, 1'b0, 1'b1, 1'b1, gnt, data, drops);
        for (int k = 0; k < 3; k++) add(1'b1, req, 1'b0, 1'b1, 1'b0, 4'b0000, 32'd0, drops);
    endtask

    initial begin
        logic [95:0] s;
        logic [3:0]  rr[5];
        bus.EN  = 1'b0;
        bus.REQ = 4'b0000;

        s = SEEDS;
        for (int k = 0; k < 16; k++) begin
            g[k] = s[95:64] ^ s[63:32] ^ s[31:0];
            s    = taus_step(s);
        end

        // seed and first word, then four words to requester 0
        add(1'b1, 4'b0001, 1'b1, 1'b1, 1'b0, 4'b0000, 32'd0, 16'd0);
        add(1'b1, 4'b0001, 1'b0, 1'b1, 1'b0, 4'b0000, 32'd0, 16'd0);
        for (int k = 0; k < 4; k++) add_sample(4'b0001, 4'b0001, g[k], 16'd0);
        // round robin from LAST=0 with all requesting
        rr = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        for (int k = 0; k < 5; k++) add_sample(4'b1111, rr[k], g[4 + k], 16'd0);
        // three unconsumed samples
        for (int k = 0; k < 3; k++) begin
            for (int p = 0; p < 3; p++) add(1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 32'd0, 16'(k));
            add(1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 32'd0, 16'(k + 1));
        end
        // late request at ph2, then one grant per sample
        add(1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 32'd0, 16'd3);
        add(1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 32'd0, 16'd3);
        add(1'b1, 4'b0100, 1'b0, 1'b1, 1'b1, 4'b0100, g[12], 16'd3);
        add(1'b1, 4'b0100, 1'b0, 1'b1, 1'b0, 4'b0000, 32'd0, 16'd3);
        add(1'b1, 4'b0100, 1'b0, 1'b1, 1'b1, 4'b0100, g[13], 16'd3);
        // disable mid-run, re-enable restarts from the seed word
        add(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 32'd0, 16'd3);
        add(1'b1, 4'b0001, 1'b1, 1'b1, 1'b0, 4'b0000, 32'd0, 16'd3);
        add(1'b1, 4'b0001, 1'b0, 1'b1, 1'b0, 4'b0000, 32'd0, 16'd3);
        add(1'b1, 4'b0001, 1'b0, 1'b1, 1'b1, 4'b0001, g[0], 16'd3);
        for (int k = 0; k < 3; k++) add(1'b1, 4'b1111, 1'b0, 1'b1, 1'b0, 4'b0000, 32'd0, 16'd3);

        repeat (2) @(posedge CK);
        #1;
        chk("reset st", 32'(bus.ST_OUT), 32'd0);
        chk("reset busy", 32'(bus.BUSY), 32'd0);
        chk("reset vld", 32'(bus.VLD), 32'd0);
        chk("reset gnt", 32'(bus.GNT), 32'd0);
        chk("reset data", bus.DATA, 32'd0);
        chk("reset drops", 32'(bus.DROPS), 32'd0);
        RB = 1'b0;

        foreach (tbl[i]) begin
            bus.EN  = tbl[i].en;
            bus.REQ = tbl[i].req;
            @(posedge CK);
            #1;
            chk($sformatf("row%0d st", i), 32'(bus.ST_OUT), 32'(tbl[i].st));
            chk($sformatf("row%0d busy", i), 32'(bus.BUSY), 32'(tbl[i].busy));
            chk($sformatf("row%0d vld", i), 32'(bus.VLD), 32'(tbl[i].vld));
            chk($sformatf("row%0d gnt", i), 32'(bus.GNT), 32'(tbl[i].gnt));
            chk($sformatf("row%0d drops", i), 32'(bus.DROPS), 32'(tbl[i].drops));
            if (tbl[i].vld) chk($sformatf("row%0d data", i), bus.DATA, tbl[i].data);
        end

        // asynchronous reset in the cycle a grant is due
        #3 RB = 1'b1;
        #1;
        chk("async st", 32'(bus.ST_OUT), 32'd0);
        chk("async busy", 32'(bus.BUSY), 32'd0);
        chk("async vld", 32'(bus.VLD), 32'd0);
        chk("async gnt", 32'(bus.GNT), 32'd0);
        chk("async data", bus.DATA, 32'd0);
        chk("async drops", 32'(bus.DROPS), 32'd0);
        @(posedge CK);
        #1;
        chk("held reset vld", 32'(bus.VLD), 32'd0);
        RB      = 1'b0;
        bus.EN  = 1'b1;
        bus.REQ = 4'b1111;
        @(posedge CK);
        #1;
        chk("restart st", 32'(bus.ST_OUT), 32'd1);
        @(posedge CK);
        #1;
        chk("restart st off", 32'(bus.ST_OUT), 32'd0);
        @(posedge CK);
        #1;
        chk("restart vld", 32'(bus.VLD), 32'd1);
        chk("restart gnt", 32'(bus.GNT), 32'b0001);
        chk("restart data", bus.DATA, 32'h00000003);

        // drop counting, full width and saturating two-bit counter
        RB = 1'b1;
        @(posedge CK);
        #1;
        RB      = 1'b0;
        bus.EN  = 1'b1;
        bus.REQ = 4'b0000;
        repeat (2) @(posedge CK);
        #1;
        for (int k = 0; k < 5; k++) begin
            repeat (4) @(posedge CK);
            #1;
            chk($sformatf("drops16 s%0d", k), 32'(bus.DROPS), 32'(k + 1));
            chk($sformatf("drops2 s%0d", k), 32'(bus2.DROPS), (k + 1 > 3) ? 32'd3 : 32'(k + 1));
            chk($sformatf("idle vld s%0d", k), 32'(bus.VLD), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
